// File: rtl/rng_share_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : rng_share_arbiter_pkg
// Brief   : Shared game constants and arbiter state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rng_share_arbiter_pkg;

  // Screen width in pixels; also bounds platform drawing.
  localparam int SCREEN_X_LIMIT = 320;
  // Width of the shared pseudo-random generator value.
  localparam int RAND_W = 9;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    GRANT = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rng_share_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// Module  : rng_share_arbiter_rr_pick
// Brief   : Combinational round-robin selector. Returns the first asserted
//           request at or after the pointer, ascending with wrap.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rng_share_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  // Scan offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[PTR_W'(idx)]) begin
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rng_share_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rng_share_arbiter
// Brief   : Shares one pseudo-random generator among platform-spawn
//           requesters. Advances the generator STEPS times per attempt,
//           range-qualifies the value against X_LIMIT (retry, then fold) and
//           hands it out with a one-cycle grant/valid pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rng_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RAND_W    = rng_share_arbiter_pkg::RAND_W,
  parameter int X_LIMIT   = rng_share_arbiter_pkg::SCREEN_X_LIMIT,
  parameter int STEPS     = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [RAND_W-1:0]  rand_data,
  output logic               rand_valid,
  output logic               rng_enable,
  input  logic [RAND_W-1:0]  rng_value,
  output logic               busy
);

  import rng_share_arbiter_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [RAND_W:0] LIMIT_EXT = (RAND_W + 1)'(X_LIMIT);

  arb_state_t         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [3:0]         step_cnt;
  logic [2:0]         retry_cnt;
  logic [RAND_W:0]    value_ext;
  logic [RAND_W:0]    fold_ext;
  logic               in_range;
  logic               retry_left;
  logic [PTR_W-1:0]   ptr_next;

  rng_share_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  // One extra bit lets X_LIMIT reach 2^RAND_W without overflow.
  assign value_ext  = {1'b0, rng_value};
  assign fold_ext   = value_ext - LIMIT_EXT;
  assign in_range   = (value_ext < LIMIT_EXT);
  assign retry_left = (retry_cnt < 3'(MAX_RETRY));
  assign ptr_next   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign busy       = (state != IDLE);

  // Sequencer: arbitrate, step the generator, qualify, then pulse the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      winner     <= '0;
      step_cnt   <= '0;
      retry_cnt  <= '0;
      gnt        <= '0;
      rand_valid <= 1'b0;
      rand_data  <= '0;
      rng_enable <= 1'b0;
    end else begin
      gnt        <= '0;
      rand_valid <= 1'b0;
      rng_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            winner     <= pick_idx;
            step_cnt   <= 4'(STEPS);
            retry_cnt  <= '0;
            rng_enable <= 1'b1;
            state      <= STEP;
          end
        end
        STEP: begin
          step_cnt <= step_cnt - 1'b1;
          if (step_cnt == 4'd1) begin
            state <= CHECK;
          end else begin
            rng_enable <= 1'b1;
          end
        end
        CHECK: begin
          if (!in_range && retry_left) begin
            retry_cnt  <= retry_cnt + 1'b1;
            step_cnt   <= 4'(STEPS);
            rng_enable <= 1'b1;
            state      <= STEP;
          end else begin
            rand_data <= in_range ? rng_value : fold_ext[RAND_W-1:0];
            // The grant pulse is registered here so it is present for the
            // whole GRANT cycle; a requester that has already withdrawn
            // gets nothing and the pointer stays put.
            if (req[winner]) begin
              gnt        <= NUM_REQ'(1) << winner;
              rand_valid <= 1'b1;
              ptr        <= ptr_next;
            end
            state <= GRANT;
          end
        end
        GRANT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rng_share_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_rng_share_arbiter
// Brief   : Self-checking bench for rng_share_arbiter: table vectors,
//           hand-written corner sequences and randomized transactions checked
//           against a transaction-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rng_share_arbiter;

  localparam int NREQ  = 4;
  localparam int RW    = 9;
  localparam int XL    = 320;
  localparam int STEPS = 2;
  localparam int MRTY  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic [RW-1:0]   rand_data;
  logic            rand_valid;
  logic            rng_enable;
  logic [RW-1:0]   rng_value = '0;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int mptr  = 0;
  int fill_val = 50;
  logic [RW-1:0] script[$];

  typedef struct {
    logic [3:0]       mask;
    int               nval;
    logic [3:0][8:0]  vals;
    logic [3:0]       exp_gnt;
    logic [8:0]       exp_data;
    int               exp_lat;
  } vec_t;

  vec_t tbl[7];

  rng_share_arbiter #(
    .NUM_REQ   (NREQ),
    .RAND_W    (RW),
    .X_LIMIT   (XL),
    .STEPS     (STEPS),
    .MAX_RETRY (MRTY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .gnt        (gnt),
    .rand_data  (rand_data),
    .rand_valid (rand_valid),
    .rng_enable (rng_enable),
    .rng_value  (rng_value),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Generator model: advances on the edge after enable, playing the script.
  always @(posedge clk) begin
    if (rng_enable) begin
      if (script.size() > 0) rng_value <= script.pop_front();
      else                   rng_value <= RW'(fill_val);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One attempt: STEPS advances, the last of which presents value v.
  task automatic push_attempt(input int v);
    for (int s = 0; s < STEPS - 1; s++) script.push_back(RW'($urandom_range(0, 511)));
    script.push_back(RW'(v));
  endtask

  function automatic int rr_model(input logic [3:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] m, input int n,
                              input int v0, input int v1, input int v2, input int v3,
                              input logic [3:0] g, input int d, input int l);
    vec_t v;
    v.mask = m; v.nval = n;
    v.vals[0] = 9'(v0); v.vals[1] = 9'(v1); v.vals[2] = 9'(v2); v.vals[3] = 9'(v3);
    v.exp_gnt = g; v.exp_data = 9'(d); v.exp_lat = l;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    script.delete();
    reset = 1'b0;
    mptr  = 0;
  endtask

  // Drive one arbitration from an IDLE negedge; return at the next IDLE negedge.
  task automatic run_txn(input logic [3:0] mask, input bit withdraw,
                         input logic [3:0] exp_gnt, input logic [8:0] exp_data,
                         input int exp_lat, input string name);
    int  k;
    int  en;
    bit  seen;
    k = 0; en = 0; seen = 1'b0;
    req = mask;
    if (withdraw) begin
      for (int c = 1; c <= exp_lat + 1; c++) begin
        @(negedge clk);
        if (c == 1) req = '0;
        if (gnt != '0 || rand_valid) seen = 1'b1;
      end
      chk({name, " withdrawn-grant"}, 32'(seen), 32'd0);
      chk({name, " idle-after"}, 32'(busy), 32'd0);
    end else begin
      while (!seen && k < 40) begin
        @(negedge clk);
        k++;
        if (rng_enable) en++;
        if (gnt != '0 || rand_valid) seen = 1'b1;
      end
      chk({name, " grant-seen"}, 32'(seen), 32'd1);
      if (seen) begin
        chk({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({name, " valid"}, 32'(rand_valid), 32'd1);
        chk({name, " data"}, 32'(rand_data), 32'(exp_data));
        chk({name, " latency"}, 32'(k), 32'(exp_lat));
        chk({name, " enables"}, 32'(en), 32'((exp_lat - 1) / (STEPS + 1) * STEPS));
      end
      mptr = (onehot_idx(exp_gnt) + 1) % NREQ;
      req = '0;
      @(negedge clk);
      chk({name, " idle-after"}, 32'(busy | rand_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mask;
    int         w;
    int         v;
    int         a;
    int         dat;
    bit         wd;
    int         got;
    bit         seen;

    tbl[0] = mk(4'b0010, 1, 100,   0,   0,   0, 4'b0010, 100,  4);
    tbl[1] = mk(4'b0010, 2, 400, 250,   0,   0, 4'b0010, 250,  7);
    tbl[2] = mk(4'b0001, 4, 500, 500, 500, 500, 4'b0001, 180, 13);
    tbl[3] = mk(4'b1111, 1, 319,   0,   0,   0, 4'b0010, 319,  4);
    tbl[4] = mk(4'b1001, 2, 320,   0,   0,   0, 4'b1000,   0,  7);
    tbl[5] = mk(4'b1100, 4, 511, 511, 511, 320, 4'b0100,   0, 13);
    tbl[6] = mk(4'b0011, 1,   7,   0,   0,   0, 4'b0001,   7,  4);

    // Reset state
    do_reset();
    chk("reset gnt",    32'(gnt),        32'd0);
    chk("reset valid",  32'(rand_valid), 32'd0);
    chk("reset data",   32'(rand_data),  32'd0);
    chk("reset enable", 32'(rng_enable), 32'd0);
    chk("reset busy",   32'(busy),       32'd0);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      script.delete();
      for (int j = 0; j < tbl[i].nval; j++) push_attempt(int'(tbl[i].vals[j]));
      run_txn(tbl[i].mask, 1'b0, tbl[i].exp_gnt, tbl[i].exp_data, tbl[i].exp_lat,
              $sformatf("vec%0d", i));
    end

    // Round-robin with all requesters held
    do_reset();
    fill_val = 50;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      seen = 1'b0;
      got  = -1;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (gnt != '0) begin
          seen = 1'b1;
          got  = onehot_idx(gnt);
        end
      end
      chk($sformatf("rr grant%0d", g), 32'(got), 32'(g % NREQ));
      chk($sformatf("rr data%0d", g), 32'(rand_data), 32'd50);
      if (got >= 0) req[got] = 1'b0;
      @(negedge clk);
      if (g < 4) req = 4'b1111;
      else       req = '0;
    end
    mptr = 1;

    // Requester withdraws during STEP; pointer must not move
    script.delete();
    push_attempt(100);
    run_txn(4'b0010, 1'b1, 4'b0000, 9'd0, 4, "withdraw");
    script.delete();
    push_attempt(100);
    run_txn(4'b0110, 1'b0, 4'b0010, 9'd100, 4, "after-withdraw");

    // Reset while in CHECK aborts everything
    script.delete();
    push_attempt(100);
    req = 4'b0100;
    for (int c = 0; c < 3; c++) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset gnt",    32'(gnt),        32'd0);
    chk("midreset valid",  32'(rand_valid), 32'd0);
    chk("midreset data",   32'(rand_data),  32'd0);
    chk("midreset enable", 32'(rng_enable), 32'd0);
    chk("midreset busy",   32'(busy),       32'd0);
    reset = 1'b0;
    req   = '0;
    mptr  = 0;
    script.delete();
    push_attempt(100);
    run_txn(4'b1000, 1'b0, 4'b1000, 9'd100, 4, "post-reset");

    // Randomized transactions against the transaction-level model
    for (int t = 0; t < 60; t++) begin
      script.delete();
      mask = 4'($urandom_range(1, 15));
      dat  = 0;
      a    = 0;
      for (a = 0; a <= MRTY; a++) begin
        v = int'($urandom_range(0, 511));
        push_attempt(v);
        if (v < XL) begin
          dat = v;
          break;
        end
        if (a == MRTY) dat = v - XL;
      end
      if (a > MRTY) a = MRTY;
      wd = ($urandom_range(0, 5) == 0);
      w  = rr_model(mask, mptr);
      run_txn(mask, wd, 4'(1 << w), 9'(dat), (a + 1) * (STEPS + 1) + 1,
              $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
- Shares the single 9-bit pseudo-random generator among NUM_REQ platform-spawn requesters in the NS-Shaft game.
- Sequences the generator's enable. Each grant therefore receives a value decorrelated from the previous grant by STEPS advances.
- Range-qualifies every value to the screen x-limit before handing it out with a one-cycle grant/valid pulse.
- Sits between the platform slot controllers and the random generator, inside the game-logic clock domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- RAND_W, 9: width of generator value and of rand_data.
- X_LIMIT, 320: exclusive upper bound for rand_data. Must satisfy 2^(RAND_W-1) <= X_LIMIT <= 2^RAND_W.
- STEPS, 2: generator advances per attempt (1..15).
- MAX_RETRY, 3: rejected attempts before fold fallback (0..7).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- req, in, NUM_REQ: level request per requester; held high until its gnt bit pulses.
- gnt, out, NUM_REQ: one-hot grant pulse, 1 cycle.
- rand_data, out, RAND_W: value for the granted requester; valid only while rand_valid=1.
- rand_valid, out, 1: high exactly in the gnt cycle.
- rng_enable, out, 1: advance enable to the generator.
- rng_value, in, RAND_W: current generator output; updates on the edge after rng_enable=1.
- busy, out, 1: high in any state other than IDLE.

Behaviour:

Reset state:
- gnt=0, rand_valid=0, rand_data=0, rng_enable=0, busy=0.
- Priority pointer=0, state=IDLE, retry count=0, step count=0.
- Reset asserted in any state aborts the operation immediately. No grant is issued and no partial value is retained.

FSM states: IDLE, STEP, CHECK, GRANT.

IDLE:
- If any req bit is high, latch the winner by round-robin starting at the pointer index, ascending with wrap.
- Load step count=STEPS, clear retry count, go to STEP.
- req is sampled only in IDLE. Requests rising later wait for the next arbitration.

STEP:
- rng_enable=1 each cycle; decrement step count.
- After exactly STEPS cycles, go to CHECK.
- rng_enable is 0 in every other state.

CHECK (rng_value now reflects the final advance):
- If rng_value < X_LIMIT: register rand_data=rng_value, go to GRANT.
- Else if retry count < MAX_RETRY: increment retry count, reload step count, go to STEP.
- Else (fold): rand_data=rng_value-X_LIMIT, truncated to RAND_W; go to GRANT. The parameter constraint guarantees the result is < X_LIMIT.

GRANT (single cycle):
- If the latched winner's req is still high: gnt[winner]=1, rand_valid=1, pointer=(winner+1) mod NUM_REQ.
- If it has dropped: gnt=0, rand_valid=0, value discarded, pointer unchanged.
- Return to IDLE in both cases.

Timing:
- Minimum latency from the IDLE sample to gnt: STEPS+2 cycles.
- Each retry adds STEPS+1 cycles.
- Worst case: (MAX_RETRY+1)(STEPS+1)+1 cycles.
- Back-to-back: GRANT→IDLE→arbitrate. A grant at most every STEPS+3 cycles.

Fairness and handshake rules:
- With all requesters continuously high, grants rotate 0,1,2,…,NUM_REQ-1,0.
- No requester is granted twice while another is waiting.
- Requesters must not reassert req in the cycle of their own gnt. If they do, the bit is treated as a new request at the next IDLE.
- rand_data holds its last value outside GRANT; consumers qualify it with rand_valid.

Decomposition:
- Shared game package holds:
  - SCREEN_X_LIMIT=320 and RAND_W=9, also used by platform drawing.
  - State encoding localparams IDLE=2'd0, STEP=2'd1, CHECK=2'd2, GRANT=2'd3.
- One natural sub-module: rr_pick, a combinational round-robin one-hot selector (req vector plus pointer → winner index and any_req). It is reusable for the sprite-layer arbiter.

Test Plan:
1. Single request: reset, STEPS=2, req=4'b0010, rng_value scripted to 100 after 2 enables → rng_enable high 2 cycles; gnt=4'b0010, rand_valid=1, rand_data=100 four cycles after the sample; pointer=2.
2. Rejection then accept: rng_value sequence 400 then 250 → one retry, 3 extra cycles, rand_data=250.
3. Fold fallback: MAX_RETRY=3, rng_value stuck at 500 → 4 attempts, then rand_data=180, gnt issued at cycle 13.
4. Round-robin: req=4'b1111 held, drop each bit on its gnt and reassert next cycle → grant order 0,1,2,3,0; no requester is granted twice in a row.
5. Requester withdraws: req[1] drops during STEP → no gnt, rand_valid stays 0, pointer unchanged, next arbitration restarts from the same pointer.
6. Reset mid-operation: assert reset in CHECK → next cycle all outputs 0, state IDLE; after reset release with req=4'b1000, grant goes to requester 3 with normal latency.
